// File: rtl/hpb_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hpb_wr_ctrl
// Purpose  : Host-side write initiator for the symbol-parameter RAM control
//            block. Host writes are queued in a small FIFO and issued one at a
//            time as an hpb_wr_req / rcb_wr_done handshake. The request is
//            dropped for a GAP cycle after each completion so the RAM
//            controller re-arms its accept logic.
// Options  : `HPB_TIMEOUT_EN - abandon a request after HPB_TIMEOUT_CYC cycles
//            in REQ without rcb_wr_done and pulse hpb_timeout.
// Ports    : clk, reset_n (async active-low)
//            host_valid/host_ready/host_addr/host_data/host_be : host queue in
//            hpb_wr_req/hpb_wr_addr/hpb_wr_data/hpb_wr_en       : RAM request
//            rcb_wr_done                                       : accept pulse
//            hpb_busy, hpb_wr_cnt, hpb_timeout                 : status
// Revision : 1.0 - initial release
// ============================================================================
module hpb_wr_ctrl #(
  parameter int HPB_RAM_WIDTH   = 64,
  parameter int HPB_FIFO_DEPTH  = 4,
  parameter int HPB_TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic [13:0]                host_addr,
  input  logic [HPB_RAM_WIDTH-1:0]   host_data,
  input  logic [HPB_RAM_WIDTH/8-1:0] host_be,
  output logic                       hpb_wr_req,
  output logic [13:0]                hpb_wr_addr,
  output logic [HPB_RAM_WIDTH-1:0]   hpb_wr_data,
  output logic [HPB_RAM_WIDTH/8-1:0] hpb_wr_en,
  input  logic                       rcb_wr_done,
  output logic                       hpb_busy,
  output logic [15:0]                hpb_wr_cnt,
  output logic                       hpb_timeout
);

  localparam int BE_W  = HPB_RAM_WIDTH / 8;
  localparam int PTR_W = (HPB_FIFO_DEPTH > 1) ? $clog2(HPB_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // FIFO storage (no reset needed: contents are qualified by count_q)
  logic [13:0]              mem_addr_q [HPB_FIFO_DEPTH];
  logic [HPB_RAM_WIDTH-1:0] mem_data_q [HPB_FIFO_DEPTH];
  logic [BE_W-1:0]          mem_be_q   [HPB_FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]               state_q, state_d;
  logic                     req_q, req_d;
  logic [13:0]              addr_q, addr_d;
  logic [HPB_RAM_WIDTH-1:0] data_q, data_d;
  logic [BE_W-1:0]          en_q, en_d;
  logic [15:0]              cnt_q, cnt_d;

  logic push, pop;

`ifdef HPB_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic        tmo_q, tmo_d;
`endif

  // Ready depends only on the registered count so a same-edge pop cannot
  // create a combinational path from rcb_wr_done to host_ready.
  assign host_ready = (count_q != CNT_W'(HPB_FIFO_DEPTH));
  assign push       = host_valid && host_ready;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
`ifdef HPB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          addr_d  = mem_addr_q[rd_ptr_q];
          data_d  = mem_data_q[rd_ptr_q];
          en_d    = mem_be_q[rd_ptr_q];
          req_d   = 1'b1;
          state_d = S_REQ;
`ifdef HPB_TIMEOUT_EN
          tcnt_d  = 16'd0;
`endif
        end
      end
      S_REQ: begin
        if (rcb_wr_done) begin
          req_d   = 1'b0;
          pop     = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_GAP;
        end
`ifdef HPB_TIMEOUT_EN
        // Done has priority; the timeout only fires on a cycle without it.
        else if (tcnt_q == 16'(HPB_TIMEOUT_CYC - 1)) begin
          req_d   = 1'b0;
          pop     = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_GAP;
        end else begin
          tcnt_d  = tcnt_q + 16'd1;
        end
`endif
      end
      // Request fields stay held through GAP; the controller may consume the
      // data one cycle after done.
      S_GAP:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= host_addr;
      mem_data_q[wr_ptr_q] <= host_data;
      mem_be_q[wr_ptr_q]   <= host_be;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      en_q     <= '0;
      cnt_q    <= '0;
`ifdef HPB_TIMEOUT_EN
      tcnt_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
`ifdef HPB_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign hpb_wr_req  = req_q;
  assign hpb_wr_addr = addr_q;
  assign hpb_wr_data = data_q;
  assign hpb_wr_en   = en_q;
  assign hpb_wr_cnt  = cnt_q;
  assign hpb_busy    = (count_q != '0) || (state_q != S_IDLE);
`ifdef HPB_TIMEOUT_EN
  assign hpb_timeout = tmo_q;
`else
  assign hpb_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpb_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpb_wr_ctrl
// Purpose  : Scoreboard bench for hpb_wr_ctrl. Accepted host writes are
//            queued as expected requests; a monitor pops and compares them
//            when a new request appears, and tracks occupancy, completion
//            count, spacing and timeout pulses from a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpb_wr_ctrl;
  localparam int W     = 64;
  localparam int BEW   = W / 8;
  localparam int DEPTH = 4;
`ifdef HPB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic           clk, reset_n;
  logic           host_valid, host_ready;
  logic [13:0]    host_addr;
  logic [W-1:0]   host_data;
  logic [BEW-1:0] host_be;
  logic           hpb_wr_req;
  logic [13:0]    hpb_wr_addr;
  logic [W-1:0]   hpb_wr_data;
  logic [BEW-1:0] hpb_wr_en;
  logic           rcb_wr_done;
  logic           hpb_busy;
  logic [15:0]    hpb_wr_cnt;
  logic           hpb_timeout;

  hpb_wr_ctrl #(
    .HPB_RAM_WIDTH  (W),
    .HPB_FIFO_DEPTH (DEPTH),
    .HPB_TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_be    (host_be),
    .hpb_wr_req (hpb_wr_req),
    .hpb_wr_addr(hpb_wr_addr),
    .hpb_wr_data(hpb_wr_data),
    .hpb_wr_en  (hpb_wr_en),
    .rcb_wr_done(rcb_wr_done),
    .hpb_busy   (hpb_busy),
    .hpb_wr_cnt (hpb_wr_cnt),
    .hpb_timeout(hpb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0]    a;
    logic [W-1:0]   d;
    logic [BEW-1:0] b;
  } ent_t;

  int   tests = 0;
  int   fails = 0;

  // Reference model state
  ent_t expq[$];
  ent_t held;
  int   mcount   = 0;
  int   exp_cnt  = 0;
  logic exp_tmo  = 1'b0;
  int   age      = 0;
  int   gap      = 100;
  logic prev_req = 1'b0;
  logic pending  = 1'b0;
  int   tmo_seen = 0;

  // Responder controls
  logic resp_en   = 1'b0;
  logic spur_en   = 1'b0;
  int   fixed_lat = 0;
  int   cur_lat   = 1;
  int   r_age     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected at %0t", nm, $time);
  endtask

  // Monitor / scoreboard: outputs are stable at negedge; inputs driven at
  // posedge+1 are also stable, so the model predicts the coming edge here.
  always @(negedge clk) begin
    logic acc, done_pop, tmo_pop;
    if (!reset_n) begin
      prev_req = 1'b0;
      age      = 0;
      gap      = 100;
      exp_tmo  = 1'b0;
      pending  = 1'b0;
    end else begin
      chk("host_ready", {63'd0, host_ready}, {63'd0, (mcount < DEPTH)});
      chk("wr_cnt", {48'd0, hpb_wr_cnt}, {48'd0, exp_cnt[15:0]});
      chk("timeout", {63'd0, hpb_timeout}, {63'd0, exp_tmo});
      if (hpb_timeout) tmo_seen++;
      if (mcount != 0) chk("busy_nonempty", {63'd0, hpb_busy}, 64'd1);
      if (hpb_wr_req && !prev_req) begin
        if (pending) chk("gap_exact", 64'(gap), 64'd2);
        else         chk("gap_min", {63'd0, (gap >= 2)}, 64'd1);
        if (expq.size() == 0) begin
          fail_evt("req_unexpected");
        end else begin
          held = expq.pop_front();
          chk("req_addr", {50'd0, hpb_wr_addr}, {50'd0, held.a});
          chk("req_data", hpb_wr_data, held.d);
          chk("req_be", {56'd0, hpb_wr_en}, {56'd0, held.b});
        end
      end else if (hpb_wr_req) begin
        if ({hpb_wr_addr, hpb_wr_data, hpb_wr_en} !== held) fail_evt("req_fields_unstable");
      end
      if (hpb_wr_req) begin gap = 0; age++; end
      else begin gap++; age = 0; end

      acc      = host_valid && (mcount < DEPTH);
      done_pop = rcb_wr_done && hpb_wr_req;
      tmo_pop  = 1'b0;
`ifdef HPB_TIMEOUT_EN
      tmo_pop  = hpb_wr_req && !rcb_wr_done && (age == TMO);
`endif
      exp_tmo = tmo_pop;
      if (acc) begin
        expq.push_back('{a: host_addr, d: host_data, b: host_be});
        mcount++;
      end
      if (done_pop || tmo_pop) begin
        mcount--;
        pending = (mcount != 0);
      end
      if (done_pop) exp_cnt++;
      prev_req = hpb_wr_req;
    end
  end

  // RAM-controller responder: done after cur_lat request cycles, optional
  // spurious done pulses while no request is outstanding.
  always @(posedge clk) begin
    #1;
    if (!reset_n || !hpb_wr_req) r_age = 0;
    else r_age++;
    if (hpb_wr_req) begin
      if (r_age == 1) cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      rcb_wr_done = resp_en && (r_age >= cur_lat);
    end else begin
      rcb_wr_done = spur_en && reset_n && ($urandom_range(0, 1) == 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] a, input logic [W-1:0] d, input logic [BEW-1:0] b);
    int   n   = 0;
    logic acc = 1'b0;
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    host_be    = b;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = host_ready;
      @(posedge clk);
      #1;
      n++;
    end
    host_valid = 1'b0;
    if (!acc) fail_evt("push_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(mcount == 0 && expq.size() == 0 && !hpb_wr_req) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_evt("drain_timeout");
    cyc(2);
    @(negedge clk);
    chk("busy_idle", {63'd0, hpb_busy}, 64'd0);
    cyc(1);
  endtask

  initial begin
    reset_n     = 1'b0;
    host_valid  = 1'b0;
    host_addr   = '0;
    host_data   = '0;
    host_be     = '0;
    rcb_wr_done = 1'b0;
    #23;
    chk("rst_req", {63'd0, hpb_wr_req}, 64'd0);
    chk("rst_cnt", {48'd0, hpb_wr_cnt}, 64'd0);
    chk("rst_busy", {63'd0, hpb_busy}, 64'd0);
    chk("rst_ready", {63'd0, host_ready}, 64'd1);
    chk("rst_tmo", {63'd0, hpb_timeout}, 64'd0);
    chk("rst_data", hpb_wr_data, 64'd0);
    chk("rst_addr", {50'd0, hpb_wr_addr}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(2);

    // Single write, done two cycles after req
    resp_en = 1'b1; fixed_lat = 2;
    push(14'h0010, 64'h1122334455667788, 8'hFF);
    wait_drain();
    chk("t1_cnt", {48'd0, hpb_wr_cnt}, 64'd1);

    // Fill the queue with done withheld; fifth write must wait
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) push(14'(16'h0100 + i), {$urandom, $urandom}, 8'(i + 1));
    @(negedge clk);
    chk("t2_full_ready", {63'd0, host_ready}, 64'd0);
    @(posedge clk); #1;
    fork
      push(14'h0200, 64'hDEADBEEFCAFEF00D, 8'h0F);
      begin
        cyc(6);
        @(negedge clk);
        chk("t2_held_off", {63'd0, host_ready}, 64'd0);
        resp_en = 1'b1; fixed_lat = 1;
      end
    join
    wait_drain();
    chk("t2_cnt", {48'd0, hpb_wr_cnt}, 64'd6);

    // Three queued, done on each request's second cycle
    fixed_lat = 2;
    for (int i = 0; i < 3; i++) push(14'(16'h0300 + i), {$urandom, $urandom}, 8'($urandom));
    wait_drain();
    chk("t3_cnt", {48'd0, hpb_wr_cnt}, 64'd9);

    // Spurious done pulses while idle and in GAP
    spur_en = 1'b1;
    cyc(12);
    chk("t4_idle_cnt", {48'd0, hpb_wr_cnt}, 64'd9);
    chk("t4_idle_req", {63'd0, hpb_wr_req}, 64'd0);
    fixed_lat = 0;
    push(14'h0400, {$urandom, $urandom}, 8'hA5);
    push(14'h0401, {$urandom, $urandom}, 8'h5A);
    wait_drain();
    chk("t4_cnt", {48'd0, hpb_wr_cnt}, 64'd11);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      spur_en = ($urandom_range(0, 1) == 1);
      push(14'($urandom), {$urandom, $urandom}, 8'($urandom));
      cyc($urandom_range(0, 3));
    end
    wait_drain();
    chk("rand_cnt", {48'd0, hpb_wr_cnt}, 64'd51);
    spur_en = 1'b0;

`ifdef HPB_TIMEOUT_EN
    // No done: both entries must be abandoned with a timeout pulse each
    resp_en  = 1'b0;
    tmo_seen = 0;
    push(14'h0500, {$urandom, $urandom}, 8'hFF);
    push(14'h0501, {$urandom, $urandom}, 8'h81);
    wait_drain();
    chk("t5_tmo_pulses", 64'(tmo_seen), 64'd2);
    chk("t5_cnt", {48'd0, hpb_wr_cnt}, 64'd51);
`endif

    // Reset while a request is outstanding with more queued
    resp_en = 1'b0;
    push(14'h0600, {$urandom, $urandom}, 8'h11);
    push(14'h0601, {$urandom, $urandom}, 8'h22);
    push(14'h0602, {$urandom, $urandom}, 8'h33);
    begin
      int n = 0;
      while (!hpb_wr_req && n < 20) begin cyc(1); n++; end
      if (!hpb_wr_req) fail_evt("t6_no_req");
    end
    #2;
    reset_n = 1'b0;
    expq.delete();
    mcount  = 0;
    exp_cnt = 0;
    #1;
    chk("t6_req_async", {63'd0, hpb_wr_req}, 64'd0);
    chk("t6_busy", {63'd0, hpb_busy}, 64'd0);
    chk("t6_ready", {63'd0, host_ready}, 64'd1);
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    chk("t6_post_req", {63'd0, hpb_wr_req}, 64'd0);
    chk("t6_post_cnt", {48'd0, hpb_wr_cnt}, 64'd0);
    chk("t6_post_busy", {63'd0, hpb_busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
